// File: rtl/mem_ctrl_unit.sv
// Memory-stage data-memory access decoder: access size, write enable, access request.
// Define MEM_CTRL_REG_OUT_EN to register all outputs (1-cycle latency, sync reset).
module mem_ctrl_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       data_mem_access_ready_n,
   output logic [1:0] access_size,
   output logic       write_to_data_mem,
   output logic       require_mem_access
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_NONE = 2'b11;

   logic [1:0] size_c;
   logic       wr_c;
   logic       req_c;

   // Unmatched or unknown opcode/funct3 falls to the defaults: no access.
   always_comb begin
      size_c = SZ_NONE;
      wr_c   = 1'b0;
      case (opcode)
         OP_LOAD: begin
            case (funct3)
               3'b000, 3'b100: size_c = SZ_BYTE;
               3'b001, 3'b101: size_c = SZ_HALF;
               3'b010:         size_c = SZ_WORD;
               default:        size_c = SZ_NONE;
            endcase
         end
         OP_STORE: begin
            case (funct3)
               3'b000: begin
                  size_c = SZ_BYTE;
                  wr_c   = 1'b1;
               end
               3'b001: begin
                  size_c = SZ_HALF;
                  wr_c   = 1'b1;
               end
               3'b010: begin
                  size_c = SZ_WORD;
                  wr_c   = 1'b1;
               end
               default: begin
                  size_c = SZ_NONE;
                  wr_c   = 1'b0;
               end
            endcase
         end
         default: begin
            size_c = SZ_NONE;
            wr_c   = 1'b0;
         end
      endcase
   end

   assign req_c = ~data_mem_access_ready_n;

`ifdef MEM_CTRL_REG_OUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         access_size        <= SZ_NONE;
         write_to_data_mem  <= 1'b0;
         require_mem_access <= 1'b0;
      end else begin
         access_size        <= size_c;
         write_to_data_mem  <= wr_c;
         require_mem_access <= req_c;
      end
   end
`else
   // Clock and reset are kept as ports so both builds share one footprint.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   assign access_size        = size_c;
   assign write_to_data_mem  = wr_c;
   assign require_mem_access = req_c;
`endif

endmodule

// File: tb/tb_mem_ctrl_unit.sv
// Directed scoreboard bench for mem_ctrl_unit (combinational or registered build).
// Expected outputs are queued at drive time and popped once the DUT output is due.
module tb_mem_ctrl_unit;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       data_mem_access_ready_n;
   logic [1:0] access_size;
   logic       write_to_data_mem;
   logic       require_mem_access;

   int errors;
   int checks;

   logic [3:0] exp_q[$];
   string      tag_q[$];

   mem_ctrl_unit dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .opcode                  (opcode),
      .funct3                  (funct3),
      .data_mem_access_ready_n (data_mem_access_ready_n),
      .access_size             (access_size),
      .write_to_data_mem       (write_to_data_mem),
      .require_mem_access      (require_mem_access)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic [1:0] obs,
                         input logic [1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic apply(input string tag, input logic rst,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic rdyn, input logic [1:0] esz,
                        input logic ewr, input logic ereq);
      logic [3:0] e;
      string      t;
      @(negedge clk);
      rst_n                   = rst;
      opcode                  = op;
      funct3                  = f3;
      data_mem_access_ready_n = rdyn;
      exp_q.push_back({esz, ewr, ereq});
      tag_q.push_back(tag);
`ifdef MEM_CTRL_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check1({t, ".size"}, access_size, e[3:2]);
      check1({t, ".wr"}, {1'b0, write_to_data_mem}, {1'b0, e[1]});
      check1({t, ".req"}, {1'b0, require_mem_access}, {1'b0, e[0]});
   endtask

   initial begin
      errors                  = 0;
      checks                  = 0;
      rst_n                   = 1'b1;
      opcode                  = 7'b0;
      funct3                  = 3'b0;
      data_mem_access_ready_n = 1'b1;

`ifdef MEM_CTRL_REG_OUT_EN
      apply("rst0", 1'b0, 7'b0100011, 3'b010, 1'b0, 2'b11, 1'b0, 1'b0);
      apply("rst1", 1'b0, 7'b0100011, 3'b010, 1'b0, 2'b11, 1'b0, 1'b0);
      apply("sw_reg", 1'b1, 7'b0100011, 3'b010, 1'b0, 2'b00, 1'b1, 1'b1);
      apply("sb_reg", 1'b1, 7'b0100011, 3'b000, 1'b0, 2'b10, 1'b1, 1'b1);
      apply("rst_mid", 1'b0, 7'b0100011, 3'b010, 1'b0, 2'b11, 1'b0, 1'b0);
`endif

      apply("lb",  1'b1, 7'b0000011, 3'b000, 1'b0, 2'b10, 1'b0, 1'b1);
      apply("lh",  1'b1, 7'b0000011, 3'b001, 1'b0, 2'b01, 1'b0, 1'b1);
      apply("lw",  1'b1, 7'b0000011, 3'b010, 1'b0, 2'b00, 1'b0, 1'b1);
      apply("lbu", 1'b1, 7'b0000011, 3'b100, 1'b0, 2'b10, 1'b0, 1'b1);
      apply("lhu", 1'b1, 7'b0000011, 3'b101, 1'b0, 2'b01, 1'b0, 1'b1);
      apply("l110", 1'b1, 7'b0000011, 3'b110, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("l111", 1'b1, 7'b0000011, 3'b111, 1'b0, 2'b11, 1'b0, 1'b1);

      apply("sb", 1'b1, 7'b0100011, 3'b000, 1'b0, 2'b10, 1'b1, 1'b1);
      apply("sh", 1'b1, 7'b0100011, 3'b001, 1'b0, 2'b01, 1'b1, 1'b1);
      apply("sw", 1'b1, 7'b0100011, 3'b010, 1'b0, 2'b00, 1'b1, 1'b1);

      apply("l011", 1'b1, 7'b0000011, 3'b011, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("s100", 1'b1, 7'b0100011, 3'b100, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("s011", 1'b1, 7'b0100011, 3'b011, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("s111", 1'b1, 7'b0100011, 3'b111, 1'b0, 2'b11, 1'b0, 1'b1);

      apply("branch", 1'b1, 7'b1100011, 3'b000, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("branch2", 1'b1, 7'b1100011, 3'b010, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("rtype", 1'b1, 7'b0110011, 3'b010, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("ld_bit5", 1'b1, 7'b0100111, 3'b010, 1'b0, 2'b11, 1'b0, 1'b1);
      apply("allx", 1'b1, 7'bxxxxxxx, 3'bxxx, 1'b0, 2'b11, 1'b0, 1'b1);

      apply("rdy0", 1'b1, 7'b0000011, 3'b010, 1'b0, 2'b00, 1'b0, 1'b1);
      apply("rdy1", 1'b1, 7'b0000011, 3'b010, 1'b1, 2'b00, 1'b0, 1'b0);
      apply("rdy0b", 1'b1, 7'b0000011, 3'b010, 1'b0, 2'b00, 1'b0, 1'b1);
      apply("rdy1_st", 1'b1, 7'b0100011, 3'b001, 1'b1, 2'b01, 1'b1, 1'b0);
      apply("rdy1_nop", 1'b1, 7'b0010011, 3'b000, 1'b1, 2'b11, 1'b0, 1'b0);

`ifdef MEM_CTRL_REG_OUT_EN
      apply("rst_end", 1'b0, 7'b0000011, 3'b000, 1'b0, 2'b11, 1'b0, 1'b0);
      apply("rel_end", 1'b1, 7'b0000011, 3'b000, 1'b0, 2'b10, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
